// File: rtl/fb_rect_writer.sv
// Rectangle write engine for the 4-bit-per-cell VGA frame buffer.
// Takes one rectangle command, clips it to the screen and walks the covered
// cells row-major, presenting one frame buffer write per clock.
module fb_rect_writer #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_x,
  input  logic [5:0]  cmd_y,
  input  logic [6:0]  cmd_w,
  input  logic [5:0]  cmd_h,
  input  logic [3:0]  cmd_color,
  input  logic        cmd_outline,
  input  logic        wr_stall,
  output logic [12:0] adress,
  output logic [3:0]  adat,
  output logic        we,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  // Command captured at accept
  logic [6:0]  x_q;
  logic [5:0]  y_q;
  logic [6:0]  w_q;
  logic [5:0]  h_q;
  logic [3:0]  color_q;
  logic        outline_q;

  // Clipped extents and border flags computed in SETUP
  logic [7:0]  x1_q;
  logic [6:0]  y1_q;
  logic        right_q;
  logic        bottom_q;
  logic        ol_q;

  // Walk position: current cell and address of the current row's left edge
  logic [6:0]  cx_q;
  logic [5:0]  cy_q;
  logic [12:0] rowbase_q;
  logic [12:0] addr_q;

  // Setup arithmetic; x+w and y+h carry one extra bit so they never wrap
  logic [7:0]  xw;
  logic [6:0]  yh;
  logic [7:0]  x1_c;
  logic [6:0]  y1_c;
  logic        empty_c;
  logic [12:0] base_c;

  // Walk decisions
  logic        last_col;
  logic        last_row;
  logic        interior;
  logic        at_left;
  logic        row_end;
  logic        jump;
  logic [7:0]  span;

  // Clip the registered command against the screen
  always_comb begin
    xw      = {1'b0, x_q} + {1'b0, w_q};
    yh      = {1'b0, y_q} + {1'b0, h_q};
    x1_c    = (xw > 8'(COLS)) ? 8'(COLS) : xw;
    y1_c    = (yh > 7'(ROWS)) ? 7'(ROWS) : yh;
    empty_c = (w_q == '0) || (h_q == '0) ||
              ({1'b0, x_q} >= 8'(COLS)) || ({1'b0, y_q} >= 7'(ROWS));
    base_c  = 13'(y_q) * 13'(COLS) + 13'(x_q);
  end

  // Decide where the walk goes after the current cell.
  // In an outline interior row only the left and (unclipped) right edges are
  // visited: from the left edge either jump to the right edge or, if the
  // right border is clipped away, end the row immediately.
  always_comb begin
    last_col = ({1'b0, cx_q} == (x1_q - 8'd1));
    last_row = ({1'b0, cy_q} == (y1_q - 7'd1));
    interior = ol_q && (cy_q != y_q) && !(bottom_q && last_row);
    at_left  = (cx_q == x_q);
    row_end  = last_col || (interior && at_left && !right_q);
    jump     = interior && at_left && right_q;
    span     = x1_q - 8'd1 - {1'b0, x_q};
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next state and port outputs
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    we        = 1'b0;
    done      = 1'b0;
    adress    = '0;
    adat      = '0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nx = S_SETUP;
      end
      S_SETUP: begin
        state_nx = empty_c ? S_DONE : S_RUN;
      end
      S_RUN: begin
        we     = 1'b1;
        adress = addr_q;
        adat   = color_q;
        if (!wr_stall && row_end && last_row) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Command capture, setup and cell walk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      outline_q <= 1'b0;
      x1_q      <= '0;
      y1_q      <= '0;
      right_q   <= 1'b0;
      bottom_q  <= 1'b0;
      ol_q      <= 1'b0;
      cx_q      <= '0;
      cy_q      <= '0;
      rowbase_q <= '0;
      addr_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            x_q       <= cmd_x;
            y_q       <= cmd_y;
            w_q       <= cmd_w;
            h_q       <= cmd_h;
            color_q   <= cmd_color;
            outline_q <= cmd_outline;
          end
        end
        S_SETUP: begin
          x1_q      <= x1_c;
          y1_q      <= y1_c;
          right_q   <= (xw <= 8'(COLS));
          bottom_q  <= (yh <= 7'(ROWS));
          ol_q      <= outline_q && (w_q > 7'd2) && (h_q > 6'd2);
          cx_q      <= x_q;
          cy_q      <= y_q;
          rowbase_q <= base_c;
          addr_q    <= base_c;
        end
        S_RUN: begin
          if (!wr_stall && !(row_end && last_row)) begin
            if (row_end) begin
              cx_q      <= x_q;
              cy_q      <= cy_q + 6'd1;
              rowbase_q <= rowbase_q + 13'(COLS);
              addr_q    <= rowbase_q + 13'(COLS);
            end else if (jump) begin
              cx_q   <= 7'(x1_q - 8'd1);
              addr_q <= rowbase_q + 13'(span);
            end else begin
              cx_q   <= cx_q + 7'd1;
              addr_q <= addr_q + 13'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Bench for fb_rect_writer: table of directed rectangles plus random commands,
// all checked against a set-membership model of the clipped rectangle.
module tb_fb_rect_writer;

  localparam int COLS = 80;
  localparam int ROWS = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_x = '0;
  logic [5:0]  cmd_y = '0;
  logic [6:0]  cmd_w = '0;
  logic [5:0]  cmd_h = '0;
  logic [3:0]  cmd_color = '0;
  logic        cmd_outline = 1'b0;
  logic        wr_stall = 1'b0;
  logic [12:0] adress;
  logic [3:0]  adat;
  logic        we;
  logic        busy;
  logic        done;

  fb_rect_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .cmd_outline(cmd_outline),
    .wr_stall(wr_stall),
    .adress(adress), .adat(adat), .we(we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x, y, w, h, color, outline;
    int stall_pct, stall_first;
    int exp_n, exp_first, exp_last;   // exp_n < 0: no table expectations
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int cur = 0;
  int exp_q[$];
  int got_adr[$];
  int got_dat[$];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    vectors++;
    if (act !== 32'(exp)) begin
      miscompares++;
      $display("FAIL %s (cmd %0d): got %0d expected %0d", name, cur, act, exp);
    end
  endtask

  // Reference: every cell of the clipped rectangle, row-major, filtered by the
  // outline rule. Border rows/cols beyond the screen are simply never visited.
  task automatic build_expected(input vec_t v);
    exp_q.delete();
    for (int r = v.y; r < v.y + v.h && r < ROWS; r++)
      for (int c = v.x; c < v.x + v.w && c < COLS; c++)
        if (v.outline == 0 || v.w <= 2 || v.h <= 2 || r == v.y || c == v.x ||
            r == v.y + v.h - 1 || c == v.x + v.w - 1)
          exp_q.push_back(r * COLS + c);
  endtask

  task automatic drive_cmd(input vec_t v);
    cmd_x       = v.x[6:0];
    cmd_y       = v.y[5:0];
    cmd_w       = v.w[6:0];
    cmd_h       = v.h[5:0];
    cmd_color   = v.color[3:0];
    cmd_outline = v.outline[0];
  endtask

  task automatic run_cmd(input vec_t v, input bit hold_next, input vec_t nxt);
    int t, first_we, done_t, last_wr_t, we_cycles, stall_left, waited, nexp;
    bit prev_stall_we;
    logic [12:0] prev_adr;
    logic [3:0]  prev_dat;
    got_adr.delete();
    got_dat.delete();
    build_expected(v);
    nexp = exp_q.size();
    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("ready_in_idle", 32'(waited), 0);
    check("busy_in_idle", busy, 0);
    if (!cmd_ready) return;
    drive_cmd(v);
    cmd_valid = 1'b1;
    wr_stall  = 1'b0;
    @(negedge clk);
    t = 1;
    if (hold_next) begin
      drive_cmd(nxt);
    end else begin
      cmd_valid   = 1'b0;
      cmd_x       = 7'($urandom);
      cmd_y       = 6'($urandom);
      cmd_w       = 7'($urandom);
      cmd_h       = 6'($urandom);
      cmd_color   = 4'($urandom);
      cmd_outline = 1'($urandom);
    end
    check("setup_busy", busy, 1);
    check("setup_ready", cmd_ready, 0);
    check("setup_we", we, 0);
    first_we = -1; done_t = -1; last_wr_t = -1; we_cycles = 0;
    stall_left = v.stall_first;
    prev_stall_we = 1'b0;
    prev_adr = '0;
    prev_dat = '0;
    while (t < 20000) begin
      if (prev_stall_we) begin
        check("hold_we", we, 1);
        check("hold_adr", adress, int'(prev_adr));
        check("hold_dat", adat, int'(prev_dat));
      end
      if (we) begin
        we_cycles++;
        if (first_we < 0) first_we = t;
        check("adr_range", 32'(adress < 13'(COLS * ROWS)), 1);
        if (stall_left > 0) begin
          wr_stall = 1'b1;
          stall_left--;
        end else begin
          wr_stall = ($urandom_range(0, 99) < v.stall_pct);
        end
        if (!wr_stall) begin
          got_adr.push_back(int'(adress));
          got_dat.push_back(int'(adat));
          last_wr_t = t;
        end
        prev_stall_we = wr_stall;
        prev_adr = adress;
        prev_dat = adat;
      end else begin
        wr_stall = 1'($urandom);
        prev_stall_we = 1'b0;
      end
      if (done) begin
        done_t = t;
        check("done_no_we", we, 0);
        check("done_busy", busy, 1);
        break;
      end
      @(negedge clk);
      t++;
    end
    wr_stall = 1'b0;
    check("done_seen", 32'(done_t >= 0), 1);
    check("n_writes", 32'(got_adr.size()), nexp);
    for (int i = 0; i < got_adr.size() && i < nexp; i++) begin
      check("wr_adr", 32'(got_adr[i]), exp_q[i]);
      check("wr_dat", 32'(got_dat[i]), v.color);
    end
    if (v.exp_n >= 0) begin
      check("tbl_n", 32'(got_adr.size()), v.exp_n);
      if (v.exp_n > 0 && got_adr.size() > 0) begin
        check("tbl_first", 32'(got_adr[0]), v.exp_first);
        check("tbl_last", 32'(got_adr[got_adr.size() - 1]), v.exp_last);
      end
    end
    if (nexp > 0) begin
      check("first_we_lat", 32'(first_we), 2);
      check("done_after_last", 32'(done_t), last_wr_t + 1);
    end else begin
      check("empty_done_lat", 32'(done_t), 2);
      check("empty_no_we", 32'(we_cycles), 0);
    end
    if (v.stall_pct == 0)
      check("we_cycles", 32'(we_cycles), nexp + v.stall_first);
  endtask

  vec_t tbl[13];
  vec_t none;
  vec_t rv;

  initial begin
    none = '{0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0};
    //          x   y   w   h  col ol pct sf  n   first last
    tbl[0]  = '{ 2,  3,  3,  2,  5, 0,  0, 0,   6,  242,  324};
    tbl[1]  = '{ 0,  0,  4,  3, 10, 1,  0, 0,  10,    0,  163};
    tbl[2]  = '{78, 59, 10, 10,  1, 0,  0, 0,   2, 4798, 4799};
    tbl[3]  = '{ 5,  0,  2,  1,  9, 0,  0, 3,   2,    5,    6};
    tbl[4]  = '{10, 10,  0,  5,  3, 0,  0, 0,   0,    0,    0};
    tbl[5]  = '{10, 10,  5,  0,  3, 0,  0, 0,   0,    0,    0};
    tbl[6]  = '{80,  0,  5,  5,  3, 0,  0, 0,   0,    0,    0};
    tbl[7]  = '{ 0, 60,  5,  5,  3, 0,  0, 0,   0,    0,    0};
    tbl[8]  = '{10, 10,  2,  4,  7, 1,  0, 0,   8,  810, 1051};
    tbl[9]  = '{77,  0,  5,  3,  6, 1,  0, 0,   7,   77,  239};
    tbl[10] = '{ 0, 58,  3,  5, 12, 1,  0, 0,   5, 4640, 4722};
    tbl[11] = '{ 0,  0, 80, 60, 15, 1, 20, 0, 276,    0, 4799};
    tbl[12] = '{40, 20,  6,  4,  2, 1, 40, 0,  16, 1640, 1885};

    // Reset state
    #12;
    check("rst_ready", cmd_ready, 1);
    check("rst_we", we, 0);
    check("rst_adr", adress, 0);
    check("rst_dat", adat, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cur = i;
      run_cmd(tbl[i], 1'b0, none);
    end

    // Back-to-back: second command held valid while the first runs
    cur = 100;
    run_cmd(tbl[0], 1'b1, tbl[9]);
    cur = 101;
    run_cmd(tbl[9], 1'b0, none);

    // Reset in the middle of an 80-cell fill
    cur = 200;
    rv = '{0, 5, 80, 1, 4, 0, 0, 0, -1, 0, 0};
    @(negedge clk);
    drive_cmd(rv);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_we", we, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_we", we, 0);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_adr", adress, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_we", we, 0);
    end
    cur = 201;
    run_cmd(tbl[1], 1'b0, none);

    // Random commands against the model
    for (int i = 0; i < 40; i++) begin
      cur = 300 + i;
      rv.x = $urandom_range(0, 85);
      rv.y = $urandom_range(0, 63);
      rv.w = $urandom_range(0, 127);
      rv.h = $urandom_range(0, 8);
      rv.color = $urandom_range(0, 15);
      rv.outline = $urandom_range(0, 1);
      rv.stall_pct = (i % 4 == 0) ? 0 : 25;
      rv.stall_first = 0;
      rv.exp_n = -1;
      run_cmd(rv, 1'b0, none);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
